// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit 7-segment scan controller.
// Divides CLK into DIV-cycle digit slots, steps SEL through 0..3, snapshots
// {DP_MASK, DIGITS} once per frame and presents the registered BCD/DP/BLANK
// for the current slot. Optional leading-zero blanking is enabled by
// defining LEADING_ZERO_SUPPRESS_EN.
module display_scan_ctrl #(
    parameter int unsigned DIV       = 100000,
    parameter int unsigned BLANK_CYC = 2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP_MASK,
    output logic [1:0]  SEL,
    output logic [3:0]  BCD,
    output logic        DP,
    output logic        BLANK,
    output logic        FRAME
);

    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [19:0]     snap_q, snap_d;  // {dp[3:0], digit3..digit0}
    logic [3:0]      bcd_q, bcd_d;
    logic            dp_q, dp_d;
    logic            blank_q, blank_d;
    logic            frame_q, frame_d;
    logic            tick;
    logic            wrap;
    logic            suppress;

    // Prescaler, digit index and once-per-frame snapshot.
    always_comb begin
        tick   = EN && (cnt_q == CntMax);
        wrap   = tick && (sel_q == 2'd3);
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        snap_d = snap_q;
        if (tick) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
        end else if (EN) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (wrap) begin
            snap_d = {DP_MASK, DIGITS};
        end
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    // A slot is blanked when it and every higher digit are zero and its DP is off.
    always_comb begin
        suppress = 1'b0;
        case (sel_d)
            2'd3: suppress = (snap_d[15:12] == 4'h0) && !snap_d[19];
            2'd2: suppress = (snap_d[15:8] == 8'h00) && !snap_d[18];
            2'd1: suppress = (snap_d[15:4] == 12'h000) && !snap_d[17];
            default: suppress = 1'b0;
        endcase
    end
`else
    // Leading zeros are always shown.
    always_comb begin
        suppress = 1'b0;
    end
`endif

    // Outputs follow the post-edge index and snapshot so a new frame shows new data at once.
    always_comb begin
        bcd_d = 4'h0;
        case (sel_d)
            2'd0: bcd_d = snap_d[3:0];
            2'd1: bcd_d = snap_d[7:4];
            2'd2: bcd_d = snap_d[11:8];
            2'd3: bcd_d = snap_d[15:12];
            default: bcd_d = 4'h0;
        endcase
        dp_d    = snap_d[16 + int'(sel_d)];
        blank_d = !EN || (32'(cnt_d) < BLANK_CYC) || suppress;
        frame_d = wrap;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            snap_q  <= 20'h0;
            bcd_q   <= 4'h0;
            dp_q    <= 1'b0;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            frame_q <= frame_d;
        end
    end

    assign SEL   = sel_q;
    assign BCD   = bcd_q;
    assign DP    = dp_q;
    assign BLANK = blank_q;
    assign FRAME = frame_q;

endmodule
